sm_cache_node: RTL and testbench
================================

Name: sm_cache_node

Overview:
- Cache-side coherence controller for one cache line (one node): the stage directly upstream of the directory state machine.
- Accepts CPU read/write requests and checks them against the stored tag and line state (MSI).
- Issues readMiss / writeMiss / writeBack messages to the directory.
- Consumes the directory's dataValueReply, invalidate and fetch outputs to complete misses and to downgrade or invalidate the line.

Parameters:
TAG_W, 4, width of the line address tag compared on every CPU access.

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
cpuReq  input  1  CPU access request; sampled only when cpuReady=1
cpuWe  input  1  1=write, 0=read; qualifies cpuReq
cpuTag  input  TAG_W  tag of requested address
cpuReady  output  1  1 when controller can accept a request (states I, S, M)
cpuDone  output  1  one-cycle pulse: request completed (hit or miss filled)
readMiss  output  1  one-cycle pulse to directory
writeMiss  output  1  one-cycle pulse to directory
writeBack  output  1  one-cycle pulse to directory (data returned/evicted)
missTag  output  TAG_W  tag accompanying readMiss/writeMiss/writeBack
dataValueReply  input  1  directory reply completing an outstanding miss
invalidateIn  input  1  directory invalidate for this line
fetchIn  input  1  directory fetch (owner must write back)
currentState  output  3  controller state encoding (below)

Behaviour:
- Reset (async, active-high): state=I; storedTag=0; cpuReady=1; all pulse outputs=0; missTag=0.
- All outputs are registered. Pulse outputs default to 0 every cycle unless set by the transition below.
- State encoding: I=000, S=001, M=010, WB=011, RD_WAIT=100, WR_WAIT=101. cpuReady=1 only in I/S/M.
- hit = (state is S or M) and cpuTag==storedTag.
- Directory inputs have priority over a CPU request in the same cycle; the CPU request is not accepted that cycle and must be held.
- Directory inputs by state:
  - S: invalidateIn -> I. fetchIn ignored.
  - M: fetchIn and/or invalidateIn -> writeBack=1, missTag=storedTag. Next state: I if invalidateIn, else S.
  - I: invalidateIn and fetchIn ignored.
- CPU in I: read -> readMiss=1, missTag=cpuTag, RD_WAIT. Write -> writeMiss=1, missTag=cpuTag, WR_WAIT.
- CPU in S:
  - read hit -> cpuDone=1, stay S.
  - write hit -> writeMiss=1 (upgrade), WR_WAIT.
  - any miss -> silent drop of the line, then as from I.
- CPU in M:
  - read or write hit -> cpuDone=1, stay M.
  - miss -> writeBack=1, missTag=storedTag, latch pendingWe/pendingTag, go to WB.
- WB (exactly one cycle): readMiss or writeMiss per pendingWe, missTag=pendingTag, then RD_WAIT/WR_WAIT.
- On every miss issue, storedTag <= requested tag.
- RD_WAIT: dataValueReply -> cpuDone=1, S. WR_WAIT: dataValueReply -> cpuDone=1, M.
- In wait states invalidateIn and fetchIn are ignored (stale for the old line); no timeout. Controller waits indefinitely.
- cpuReq while cpuReady=0 is ignored. The CPU holds the request until cpuDone.
- Miss latency: request edge -> miss pulse 1 cycle later (2 cycles if eviction through WB). cpuDone is registered 1 cycle after dataValueReply. Hit latency is 1 cycle.
- dataValueReply outside a wait state is ignored.
- Reset asserted mid-miss returns to I immediately, with no pulses issued. A reply arriving after reset is ignored.

Test Plan:
- Reset, cpuReq read tag=3 in I -> readMiss pulse with missTag=3, state=100; dataValueReply -> cpuDone 1 cycle later, state=001. Repeat read tag=3 -> cpuDone next cycle, no directory pulse.
- In S tag=3, write tag=3 -> writeMiss pulse, state=101; reply -> cpuDone, state=010.
- In M tag=3, write tag=5 -> writeBack with missTag=3, next cycle writeMiss with missTag=5, then WR_WAIT. Reply -> M, storedTag=5.
- In M, fetchIn=1 -> writeBack pulse, state=S. In M, fetchIn=1 and invalidateIn=1 together -> single writeBack pulse, state=I.
- In S, invalidateIn and a cpuReq read hit in the same cycle -> state=I with no cpuDone. Held request then issues readMiss the following cycle.
- Assert reset while state=RD_WAIT -> state=I and outputs 0 asynchronously. A subsequent dataValueReply produces no cpuDone.

Source files
------------

// File: rtl/sm_cache_node_if.sv
// Handshake and directory message bundle between a CPU, one cache-line
// coherence controller and the directory.
interface sm_cache_node_if #(
  parameter int TAG_W = 4
);
  logic             cpuReq;
  logic             cpuWe;
  logic [TAG_W-1:0] cpuTag;
  logic             cpuReady;
  logic             cpuDone;
  logic             readMiss;
  logic             writeMiss;
  logic             writeBack;
  logic [TAG_W-1:0] missTag;
  logic             dataValueReply;
  logic             invalidateIn;
  logic             fetchIn;
  logic [2:0]       currentState;

  modport master (
    output cpuReq, cpuWe, cpuTag,
    output dataValueReply, invalidateIn, fetchIn,
    input  cpuReady, cpuDone,
    input  readMiss, writeMiss, writeBack, missTag,
    input  currentState
  );

  modport slave (
    input  cpuReq, cpuWe, cpuTag,
    input  dataValueReply, invalidateIn, fetchIn,
    output cpuReady, cpuDone,
    output readMiss, writeMiss, writeBack, missTag,
    output currentState
  );
endinterface

// File: rtl/sm_cache_node.sv
// MSI cache-side coherence controller for a single line: turns CPU accesses
// into directory miss/writeback messages and applies directory downgrades.
module sm_cache_node #(
  parameter int TAG_W = 4
) (
  input logic         clock,
  input logic         reset,
  sm_cache_node_if.slave bus
);

  localparam logic [2:0] ST_I  = 3'b000;
  localparam logic [2:0] ST_S  = 3'b001;
  localparam logic [2:0] ST_M  = 3'b010;
  localparam logic [2:0] ST_WB = 3'b011;
  localparam logic [2:0] ST_RD = 3'b100;
  localparam logic [2:0] ST_WR = 3'b101;

  logic [2:0]       state, state_n;
  logic [TAG_W-1:0] stored_tag, stored_tag_n;
  logic [TAG_W-1:0] pend_tag, pend_tag_n;
  logic             pend_we, pend_we_n;
  logic [TAG_W-1:0] miss_tag, miss_tag_n;
  logic             done_q, done_n;
  logic             rd_q, rd_n;
  logic             wr_q, wr_n;
  logic             wb_q, wb_n;
  logic             ready_q, ready_n;
  logic             hit;
  logic             fresh;

  assign hit = ((state == ST_S) || (state == ST_M))
            && (bus.cpuTag == stored_tag);

  always_comb begin
    state_n      = state;
    stored_tag_n = stored_tag;
    pend_tag_n   = pend_tag;
    pend_we_n    = pend_we;
    miss_tag_n   = miss_tag;
    done_n       = 1'b0;
    rd_n         = 1'b0;
    wr_n         = 1'b0;
    wb_n         = 1'b0;
    fresh        = 1'b0;

    unique case (state)
      ST_I: begin
        fresh = bus.cpuReq;
      end
      ST_S: begin
        if (bus.invalidateIn) begin
          state_n = ST_I;
        end else if (bus.cpuReq) begin
          if (hit && !bus.cpuWe) begin
            done_n = 1'b1;
          end else begin
            // write hit upgrades; any miss drops the clean line silently
            fresh = 1'b1;
          end
        end
      end
      ST_M: begin
        if (bus.fetchIn || bus.invalidateIn) begin
          wb_n       = 1'b1;
          miss_tag_n = stored_tag;
          state_n    = bus.invalidateIn ? ST_I : ST_S;
        end else if (bus.cpuReq) begin
          if (hit) begin
            done_n = 1'b1;
          end else begin
            wb_n       = 1'b1;
            miss_tag_n = stored_tag;
            pend_we_n  = bus.cpuWe;
            pend_tag_n = bus.cpuTag;
            state_n    = ST_WB;
          end
        end
      end
      ST_WB: begin
        rd_n         = !pend_we;
        wr_n         = pend_we;
        miss_tag_n   = pend_tag;
        stored_tag_n = pend_tag;
        state_n      = pend_we ? ST_WR : ST_RD;
      end
      ST_RD: begin
        if (bus.dataValueReply) begin
          done_n  = 1'b1;
          state_n = ST_S;
        end
      end
      ST_WR: begin
        if (bus.dataValueReply) begin
          done_n  = 1'b1;
          state_n = ST_M;
        end
      end
      default: begin
        state_n = ST_I;
      end
    endcase

    if (fresh) begin
      rd_n         = !bus.cpuWe;
      wr_n         = bus.cpuWe;
      miss_tag_n   = bus.cpuTag;
      stored_tag_n = bus.cpuTag;
      state_n      = bus.cpuWe ? ST_WR : ST_RD;
    end

    ready_n = (state_n == ST_I) || (state_n == ST_S)
           || (state_n == ST_M);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_I;
      stored_tag <= '0;
      pend_tag   <= '0;
      pend_we    <= 1'b0;
      miss_tag   <= '0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wb_q       <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state      <= state_n;
      stored_tag <= stored_tag_n;
      pend_tag   <= pend_tag_n;
      pend_we    <= pend_we_n;
      miss_tag   <= miss_tag_n;
      done_q     <= done_n;
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      wb_q       <= wb_n;
      ready_q    <= ready_n;
    end
  end

  assign bus.cpuReady     = ready_q;
  assign bus.cpuDone      = done_q;
  assign bus.readMiss     = rd_q;
  assign bus.writeMiss    = wr_q;
  assign bus.writeBack    = wb_q;
  assign bus.missTag      = miss_tag;
  assign bus.currentState = state;

endmodule

// File: tb/tb_sm_cache_node.sv
// Directed bench for sm_cache_node: each step queues the outputs expected
// after the next edge and the sampled DUT outputs are checked against them.
module tb_sm_cache_node;

  localparam int TAG_W = 4;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_DONE = 4'b1000;
  localparam logic [3:0] P_RD   = 4'b0100;
  localparam logic [3:0] P_WR   = 4'b0010;
  localparam logic [3:0] P_WB   = 4'b0001;

  localparam logic [2:0] S_I  = 3'b000;
  localparam logic [2:0] S_S  = 3'b001;
  localparam logic [2:0] S_M  = 3'b010;
  localparam logic [2:0] S_WB = 3'b011;
  localparam logic [2:0] S_RD = 3'b100;
  localparam logic [2:0] S_WR = 3'b101;

  typedef struct packed {
    logic [3:0]       pulses;
    logic [TAG_W-1:0] tag;
    logic [2:0]       st;
    logic             rdy;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  sm_cache_node_if #(.TAG_W(TAG_W)) bus ();

  sm_cache_node #(.TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_out(input logic [3:0] p, input logic [TAG_W-1:0] t,
                            input logic [2:0] s, input logic r);
    exp_t e;
    e.pulses = p;
    e.tag    = t;
    e.st     = s;
    e.rdy    = r;
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    logic [3:0] obs;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard: observed empty queue, expected entry", tag);
    end else begin
      e   = sb.pop_front();
      obs = {bus.cpuDone, bus.readMiss, bus.writeMiss, bus.writeBack};
      checks++;
      assert (obs === e.pulses) else begin
        errors++;
        $error("FAIL %s pulses: observed %b expected %b", tag, obs, e.pulses);
      end
      checks++;
      assert (bus.missTag === e.tag) else begin
        errors++;
        $error("FAIL %s missTag: observed %0d expected %0d",
               tag, bus.missTag, e.tag);
      end
      checks++;
      assert (bus.currentState === e.st) else begin
        errors++;
        $error("FAIL %s state: observed %b expected %b",
               tag, bus.currentState, e.st);
      end
      checks++;
      assert (bus.cpuReady === e.rdy) else begin
        errors++;
        $error("FAIL %s cpuReady: observed %b expected %b",
               tag, bus.cpuReady, e.rdy);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    #1;
    check_now(tag);
  endtask

  task automatic cpu(input logic req, input logic we, input logic [TAG_W-1:0] t);
    bus.cpuReq = req;
    bus.cpuWe  = we;
    bus.cpuTag = t;
  endtask

  task automatic dir(input logic reply, input logic inv, input logic fetch);
    bus.dataValueReply = reply;
    bus.invalidateIn   = inv;
    bus.fetchIn        = fetch;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    cpu(1'b0, 1'b0, 4'd0);
    dir(1'b0, 1'b0, 1'b0);

    expect_out(P_NONE, 4'd0, S_I, 1'b1);
    tick("reset");
    reset = 1'b0;

    expect_out(P_NONE, 4'd0, S_I, 1'b1);
    dir(1'b0, 1'b1, 1'b1);
    tick("i_dir_ignored");
    dir(1'b0, 1'b0, 1'b0);

    cpu(1'b1, 1'b0, 4'd3);
    expect_out(P_RD, 4'd3, S_RD, 1'b0);
    tick("rd_miss");
    expect_out(P_NONE, 4'd3, S_RD, 1'b0);
    tick("rd_wait");
    dir(1'b1, 1'b0, 1'b0);
    expect_out(P_DONE, 4'd3, S_S, 1'b1);
    tick("rd_fill");
    cpu(1'b0, 1'b0, 4'd3);
    dir(1'b0, 1'b0, 1'b0);

    cpu(1'b1, 1'b0, 4'd3);
    expect_out(P_DONE, 4'd3, S_S, 1'b1);
    tick("s_rd_hit");
    cpu(1'b0, 1'b0, 4'd3);
    dir(1'b1, 1'b0, 1'b1);
    expect_out(P_NONE, 4'd3, S_S, 1'b1);
    tick("s_idle_stray");
    dir(1'b0, 1'b0, 1'b0);

    cpu(1'b1, 1'b1, 4'd3);
    expect_out(P_WR, 4'd3, S_WR, 1'b0);
    tick("s_upgrade");
    dir(1'b1, 1'b0, 1'b0);
    expect_out(P_DONE, 4'd3, S_M, 1'b1);
    tick("wr_fill");
    cpu(1'b0, 1'b0, 4'd3);
    dir(1'b0, 1'b0, 1'b0);

    cpu(1'b1, 1'b1, 4'd5);
    expect_out(P_WB, 4'd3, S_WB, 1'b0);
    tick("m_evict_wb");
    expect_out(P_WR, 4'd5, S_WR, 1'b0);
    tick("wb_wr_miss");
    dir(1'b1, 1'b0, 1'b0);
    expect_out(P_DONE, 4'd5, S_M, 1'b1);
    tick("evict_fill");
    dir(1'b0, 1'b0, 1'b0);
    cpu(1'b1, 1'b0, 4'd5);
    expect_out(P_DONE, 4'd5, S_M, 1'b1);
    tick("m_rd_hit_tag5");
    cpu(1'b0, 1'b0, 4'd5);

    dir(1'b0, 1'b0, 1'b1);
    expect_out(P_WB, 4'd5, S_S, 1'b1);
    tick("m_fetch");
    dir(1'b0, 1'b0, 1'b0);

    cpu(1'b1, 1'b1, 4'd5);
    expect_out(P_WR, 4'd5, S_WR, 1'b0);
    tick("s_upgrade2");
    dir(1'b1, 1'b0, 1'b0);
    expect_out(P_DONE, 4'd5, S_M, 1'b1);
    tick("wr_fill2");
    cpu(1'b0, 1'b0, 4'd5);

    dir(1'b0, 1'b1, 1'b1);
    expect_out(P_WB, 4'd5, S_I, 1'b1);
    tick("m_fetch_inv");
    dir(1'b0, 1'b0, 1'b0);
    expect_out(P_NONE, 4'd5, S_I, 1'b1);
    tick("single_wb");

    cpu(1'b1, 1'b0, 4'd3);
    expect_out(P_RD, 4'd3, S_RD, 1'b0);
    tick("rd_miss2");
    dir(1'b1, 1'b0, 1'b0);
    expect_out(P_DONE, 4'd3, S_S, 1'b1);
    tick("rd_fill2");
    cpu(1'b0, 1'b0, 4'd3);
    dir(1'b0, 1'b0, 1'b0);

    cpu(1'b1, 1'b0, 4'd3);
    dir(1'b0, 1'b1, 1'b0);
    expect_out(P_NONE, 4'd3, S_I, 1'b1);
    tick("s_inv_beats_hit");
    dir(1'b0, 1'b0, 1'b0);
    expect_out(P_RD, 4'd3, S_RD, 1'b0);
    tick("held_req_miss");
    dir(1'b1, 1'b0, 1'b0);
    expect_out(P_DONE, 4'd3, S_S, 1'b1);
    tick("rd_fill3");
    cpu(1'b0, 1'b0, 4'd3);
    dir(1'b0, 1'b0, 1'b0);

    cpu(1'b1, 1'b0, 4'd7);
    expect_out(P_RD, 4'd7, S_RD, 1'b0);
    tick("s_miss_drop");
    #2;
    reset = 1'b1;
    #1;
    expect_out(P_NONE, 4'd0, S_I, 1'b1);
    check_now("async_reset");
    #1;
    reset = 1'b0;
    cpu(1'b0, 1'b0, 4'd0);
    dir(1'b1, 1'b0, 1'b0);
    expect_out(P_NONE, 4'd0, S_I, 1'b1);
    tick("late_reply");
    dir(1'b0, 1'b0, 1'b0);
    expect_out(P_NONE, 4'd0, S_I, 1'b1);
    tick("post_reset_idle");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
